rx_lane_deskew: RTL and testbench
=================================

# rx_lane_deskew

Parametrised per-lane elastic deskew buffer for the PCIe receive path. It sits between the per-lane descramblers and the lane-management/unstriping stage. It absorbs lane-to-lane skew by buffering each lane until every active lane has presented an alignment marker, then releases all active lanes in lockstep. It also monitors that markers stay aligned and re-enters search on any violation.

## Interface
Parameters:
- LANES, 16, number of physical lanes.
- LANEW, 32, data bits per lane per clock (multiple of 8; symbols per lane = LANEW/8).
- DEPTH, 8, FIFO entries per lane (power of two, >= 2).
- MAX_SKEW, 5, maximum cycles allowed between the first and last lane arming.
- NW, $clog2(LANES+1), width of the lane-count input.

Ports:
- clk, in, 1, sole clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-low; clears all state.
- numberOfDetectedLanes, in, NW, active lanes are 0..N-1; values above LANES are clamped to LANES.
- mode128, in, 1: 0 = 8b/10b marker rule, 1 = 128b/130b marker rule.
- realign, in, 1, synchronous flush request from the LTSSM.
- in_valid, in, LANES, per-lane word strobe.
- in_data, in, LANES*LANEW, lane i occupies [i*LANEW +: LANEW].
- in_datak, in, LANES*LANEW/8, per-symbol K flags.
- in_start, in, LANES, block-start flag (mode128).
- in_sync, in, 2*LANES, sync header, lane i at [2i +: 2].
- out_valid, out, 1, lockstep word set valid.
- out_data, out, LANES*LANEW, aligned data; inactive lanes are driven 0.
- out_datak, out, LANES*LANEW/8, aligned K flags; inactive lanes are driven 0.
- aligned, out, 1, high while in ALIGNED.
- deskew_err, out, 1, one-cycle error pulse.
- skew_cycles, out, $clog2(MAX_SKEW+1), measured arm spread, latched on alignment.

## Operation
- Marker on lane i:
  - mode128=0: byte0 == 8'hBC with its K bit set.
  - mode128=1: in_start[i] set and in_sync == 2'b01.
  - Only symbol 0 of the lane word is inspected.
- Each lane has a DEPTH-entry FIFO holding {data, datak, marker flag}. Only active lanes are written; inactive lanes are ignored entirely.
- States:
  - SEARCH (reset state).
    - An active lane discards words until its first marker. That marker word is written and the lane becomes armed; later valid words are written normally.
    - A skew counter starts when the first lane arms and increments every cycle.
    - When all active lanes are armed, go to ALIGNED and latch the counter into skew_cycles.
    - If the counter would exceed MAX_SKEW while any active lane is unarmed, pulse deskew_err and flush.
  - ALIGNED.
    - Pop one word from every active lane in any cycle where all active FIFOs are non-empty. Register the popped set onto out_data/out_datak and set out_valid=1.
    - If not all active FIFOs are non-empty, out_valid=0 and nothing is popped.
- Error conditions in ALIGNED (each causes a deskew_err pulse and a flush to SEARCH):
  - Marker mismatch: the marker flag is set in some but not all popped active lanes.
  - Overflow: a write to a full active FIFO, in any state.
  - Lane-count change: numberOfDetectedLanes changes value.
- Flush (error, realign, or lane-count change):
  - Empty all FIFOs, clear armed flags and the skew counter, return to SEARCH.
  - out_valid=0 the following cycle.
  - realign does not pulse deskew_err.
- N=0: remain in SEARCH, no writes, out_valid=0.
- Simultaneous events:
  - realign outranks pop and write in the same cycle.
  - Overflow and mismatch in the same cycle produce one deskew_err pulse.
  - A write and a pop on the same FIFO in the same cycle are both performed, so a full FIFO is not overflowed.

## Timing
- Reset values: out_valid=0, out_data=0, out_datak=0, aligned=0, deskew_err=0, skew_cycles=0, state=SEARCH, all FIFOs empty.
- Write latency: a word sampled at edge k is in its FIFO after edge k.
- Zero-skew latency: markers sampled on all lanes at edge k give aligned=1 after edge k+1, with the marker set on out_data and out_valid=1 after the same edge k+1.
- Skew cost: each cycle of lane skew adds that many entries to the earliest lane's FIFO occupancy. DEPTH must be at least MAX_SKEW+2.
- skew_cycles counts edges between the first and last arm:
  - Same edge: 0.
  - Last lane one edge later: 1.
- Error signalling: deskew_err is high for exactly the cycle after the edge that detected the error. aligned drops on that same edge.

## Test plan
- Zero skew: N=4, mode128=0, all lanes send 0x000000BC (K0=1) at edge 10, then incrementing words → aligned=1 and out_valid=1 after edge 11, skew_cycles=0, words emerge in lockstep and in order.
- Skew 3: N=2, lane 1 marker 3 cycles after lane 0 → skew_cycles=3, lane 0 occupancy peaks at 4, outputs matched word-for-word.
- Skew timeout: N=2, MAX_SKEW=5, lane 1 marker 7 cycles late → one deskew_err pulse, FIFOs empty, state SEARCH, aligned=0.
- Marker mismatch in ALIGNED: inject marker on lane 0 only → deskew_err pulse, out_valid=0 next cycle, realignment on the next common marker.
- mode128=1, N=16: marker via in_start=1 and in_sync=2'b01 on all lanes → aligned after 1 cycle. A block with sync 2'b10 is not treated as a marker.
- Async reset asserted mid-stream and realign asserted with overflow in the same cycle → all outputs 0 immediately on reset. For the realign/overflow cycle: flush, and deskew_err stays 0.

Source files
------------

// File: rtl/rx_lane_deskew_if.sv
// Per-lane receive bus into the deskew buffer and the lockstep aligned bus out of it.
interface rx_lane_deskew_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned LANEW = 32
);
  logic [LANES-1:0]         in_valid;
  logic [LANES*LANEW-1:0]   in_data;
  logic [LANES*LANEW/8-1:0] in_datak;
  logic [LANES-1:0]         in_start;
  logic [2*LANES-1:0]       in_sync;
  logic                     out_valid;
  logic [LANES*LANEW-1:0]   out_data;
  logic [LANES*LANEW/8-1:0] out_datak;

  modport master (
    output in_valid, in_data, in_datak, in_start, in_sync,
    input  out_valid, out_data, out_datak
  );

  modport slave (
    input  in_valid, in_data, in_datak, in_start, in_sync,
    output out_valid, out_data, out_datak
  );
endinterface

// File: rtl/rx_lane_deskew.sv
// Per-lane elastic FIFOs that hold each lane until every active lane has seen an alignment
// marker, then release all active lanes in lockstep and watch that markers stay aligned.
module rx_lane_deskew #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned LANEW    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_SKEW = 5,
  parameter int unsigned NW       = $clog2(LANES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NW-1:0]                 numberOfDetectedLanes,
  input  logic                          mode128,
  input  logic                          realign,
  rx_lane_deskew_if.slave               bus,
  output logic                          aligned,
  output logic                          deskew_err,
  output logic [$clog2(MAX_SKEW+1)-1:0] skew_cycles
);

  localparam int unsigned KW = LANEW / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_SKEW + 1);
  localparam int unsigned EW = LANEW + KW + 1;
  localparam logic [AW:0]   PtrOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   PtrFull = {1'b1, {AW{1'b0}}};
  localparam logic [NW-1:0] NMax    = NW'(LANES);
  localparam logic [SW-1:0] SkewMax = SW'(MAX_SKEW);

  typedef enum logic {StSearch, StAligned} state_e;

  state_e                 r_state;
  logic [EW-1:0]          r_mem  [LANES][DEPTH];
  logic [AW:0]            r_wptr [LANES];
  logic [AW:0]            r_rptr [LANES];
  logic [LANES-1:0]       r_armed;
  logic                   r_counting;
  logic [SW-1:0]          r_cnt;
  logic [NW-1:0]          r_nprev;
  logic                   r_err;
  logic                   r_out_valid;
  logic [LANES*LANEW-1:0] r_out_data;
  logic [LANES*KW-1:0]    r_out_datak;
  logic [SW-1:0]          r_skew;

  logic [NW-1:0]          w_n;
  logic                   w_none;
  logic [LANES-1:0]       w_active, w_mark, w_empty, w_full, w_head_mark, w_wr, w_new_arm;
  logic [EW-1:0]          w_head [LANES];
  logic [LANES*LANEW-1:0] w_pop_data;
  logic [LANES*KW-1:0]    w_pop_datak;
  logic                   w_all_armed, w_go, w_all_ne, w_pop, w_mismatch, w_ovf;
  logic                   w_nchg, w_timeout, w_err, w_flush;

  always_comb begin
    w_n    = (numberOfDetectedLanes > NMax) ? NMax : numberOfDetectedLanes;
    w_none = (w_n == '0);
    for (int i = 0; i < LANES; i++) begin
      w_active[i]    = (i < int'(w_n));
      // Only symbol 0 of the lane word carries the marker.
      w_mark[i]      = mode128 ? (bus.in_start[i] && (bus.in_sync[2*i +: 2] == 2'b01))
                               : ((bus.in_data[i*LANEW +: 8] == 8'hBC) && bus.in_datak[i*KW]);
      w_empty[i]     = (r_wptr[i] == r_rptr[i]);
      w_full[i]      = ((r_wptr[i] - r_rptr[i]) == PtrFull);
      w_head[i]      = r_mem[i][r_rptr[i][AW-1:0]];
      w_head_mark[i] = w_head[i][EW-1];
      w_new_arm[i]   = (r_state == StSearch) && w_active[i] && bus.in_valid[i] &&
                       !r_armed[i] && w_mark[i];
      w_wr[i]        = w_active[i] && bus.in_valid[i] &&
                       ((r_state == StAligned) || r_armed[i] || w_mark[i]);
      w_pop_data[i*LANEW +: LANEW] = w_active[i] ? w_head[i][LANEW-1:0] : '0;
      w_pop_datak[i*KW +: KW]      = w_active[i] ? w_head[i][LANEW +: KW] : '0;
    end
    w_all_armed = !w_none && (&(r_armed | ~w_active));
    // The first lockstep pop happens on the same edge that enters ALIGNED.
    w_go        = (r_state == StSearch) && w_all_armed;
    w_all_ne    = !w_none && (&(~w_empty | ~w_active));
    w_pop       = ((r_state == StAligned) || w_go) && w_all_ne;
    w_mismatch  = w_pop && (|(w_head_mark & w_active)) && !(&(w_head_mark | ~w_active));
    // Pops cover every active lane at once, so a concurrent pop always makes room.
    w_ovf       = (|(w_wr & w_full)) && !w_pop;
    w_nchg      = (numberOfDetectedLanes != r_nprev);
    w_timeout   = (r_state == StSearch) && r_counting && (r_cnt == SkewMax) && !w_all_armed;
    w_err       = !realign &&
                  (w_ovf || w_timeout || ((r_state == StAligned) && (w_mismatch || w_nchg)));
    w_flush     = realign || w_err || w_nchg;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_wr[i] && !w_flush) begin
        r_mem[i][r_wptr[i][AW-1:0]] <= {w_mark[i], bus.in_datak[i*KW +: KW],
                                        bus.in_data[i*LANEW +: LANEW]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StSearch;
      r_armed     <= '0;
      r_counting  <= 1'b0;
      r_cnt       <= '0;
      r_nprev     <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_datak <= '0;
      r_skew      <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      r_nprev <= numberOfDetectedLanes;
      r_err   <= w_err;
      if (w_flush) begin
        r_state     <= StSearch;
        r_armed     <= '0;
        r_counting  <= 1'b0;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        for (int i = 0; i < LANES; i++) begin
          r_wptr[i] <= '0;
          r_rptr[i] <= '0;
        end
      end else begin
        r_out_valid <= w_pop;
        if (w_pop) begin
          r_out_data  <= w_pop_data;
          r_out_datak <= w_pop_datak;
        end
        for (int i = 0; i < LANES; i++) begin
          if (w_wr[i]) r_wptr[i] <= r_wptr[i] + PtrOne;
          if (w_pop && w_active[i]) r_rptr[i] <= r_rptr[i] + PtrOne;
        end
        if (r_state == StSearch) begin
          r_armed <= r_armed | w_new_arm;
          if (w_go) begin
            r_state    <= StAligned;
            r_skew     <= r_cnt;
            r_counting <= 1'b0;
          end else if (r_counting) begin
            r_cnt <= r_cnt + SW'(1);
          end else if (|w_new_arm) begin
            r_counting <= 1'b1;
            r_cnt      <= '0;
          end
        end
      end
    end
  end

  assign aligned       = (r_state == StAligned);
  assign deskew_err    = r_err;
  assign skew_cycles   = r_skew;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_datak = r_out_datak;

endmodule

// File: tb/tb_rx_lane_deskew.sv
// Directed steps for the lane deskew buffer; expected lockstep word sets are queued as they are
// driven and matched against out_data/out_datak whenever out_valid is seen.
module tb_rx_lane_deskew;
  localparam int unsigned LANES = 16;
  localparam int unsigned LANEW = 32;
  localparam int unsigned KW    = LANEW / 8;
  localparam int unsigned DW    = LANES * LANEW;
  localparam int unsigned NW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NW-1:0] n;
  logic          mode128, realign, aligned, deskew_err;
  logic [2:0]    skew_cycles;
  logic [3:0]    occ;
  int            tests = 0;
  int            fails = 0;

  logic [DW-1:0]       sb_d[$];
  logic [LANES*KW-1:0] sb_k[$];
  logic [DW-1:0]       exp_d;
  logic [LANES*KW-1:0] exp_k;

  rx_lane_deskew_if #(.LANES(LANES), .LANEW(LANEW)) bus ();

  rx_lane_deskew #(
    .LANES(LANES), .LANEW(LANEW), .DEPTH(8), .MAX_SKEW(5), .NW(NW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .numberOfDetectedLanes (n),
    .mode128               (mode128),
    .realign               (realign),
    .bus                   (bus),
    .aligned               (aligned),
    .deskew_err            (deskew_err),
    .skew_cycles           (skew_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_datak = '0;
    bus.in_start = '0;
    bus.in_sync  = '0;
  endtask

  task automatic set_lane(input int l, input logic [LANEW-1:0] d, input logic k0,
                          input logic st, input logic [1:0] sy);
    bus.in_valid[l]               = 1'b1;
    bus.in_data[l*LANEW +: LANEW] = d;
    bus.in_datak[l*KW +: KW]      = {{(KW-1){1'b0}}, k0};
    bus.in_start[l]               = st;
    bus.in_sync[2*l +: 2]         = sy;
  endtask

  // Word j of lane l: j == 0 is the 8b/10b marker (0xBC with K on symbol 0).
  function automatic logic [LANEW-1:0] wv(input int l, input int j);
    if (j == 0) return 32'h0000_00BC;
    return {8'(l), 8'(j), 8'h55, 8'(j)};
  endfunction

  task automatic push_set(input int nl, input int j);
    logic [DW-1:0]       d = '0;
    logic [LANES*KW-1:0] k = '0;
    for (int l = 0; l < nl; l++) begin
      d[l*LANEW +: LANEW] = wv(l, j);
      k[l*KW]             = (j == 0);
    end
    sb_d.push_back(d);
    sb_k.push_back(k);
  endtask

  task automatic push_bus(input int nl);
    logic [DW-1:0]       d = '0;
    logic [LANES*KW-1:0] k = '0;
    for (int l = 0; l < nl; l++) begin
      d[l*LANEW +: LANEW] = bus.in_data[l*LANEW +: LANEW];
      k[l*KW +: KW]       = bus.in_datak[l*KW +: KW];
    end
    sb_d.push_back(d);
    sb_k.push_back(k);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb_d.size() == 0) begin
        check("unexpected_out_valid", bus.out_valid, 0);
      end else begin
        exp_d = sb_d.pop_front();
        exp_k = sb_k.pop_front();
        check("out_data", bus.out_data, exp_d);
        check("out_datak", bus.out_datak, exp_k);
      end
    end
  end

  initial begin
    reset = 1'b1; n = '0; mode128 = 1'b0; realign = 1'b0;
    clr_in();
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_aligned", aligned, 0);
    check("rst_err", deskew_err, 0);
    check("rst_skew", skew_cycles, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_datak", bus.out_datak, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Zero skew, N=4; inactive lanes also carry markers and must stay invisible.
    n = 5'd4;
    tick(); tick();
    for (int l = 0; l < LANES; l++) set_lane(l, wv(l, 0), 1'b1, 1'b0, 2'b00);
    push_set(4, 0);
    tick();
    check("t1_aligned_at_k", aligned, 0);
    for (int j = 1; j <= 5; j++) begin
      for (int l = 0; l < LANES; l++) set_lane(l, wv(l, j), 1'b0, 1'b0, 2'b00);
      push_set(4, j);
      tick();
      if (j == 1) begin
        check("t1_aligned", aligned, 1);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_skew", skew_cycles, 0);
      end
    end
    clr_in();
    repeat (3) tick();
    check("t1_drained", sb_d.size(), 0);
    check("t1_idle_valid", bus.out_valid, 0);

    // Lane-count change while aligned, then skew of 3 with N=2.
    n = 5'd2;
    tick();
    check("t2_nchg_err", deskew_err, 1);
    check("t2_nchg_aligned", aligned, 0);
    tick();
    check("t2_nchg_err_clear", deskew_err, 0);
    for (int c = 0; c <= 9; c++) begin
      clr_in();
      if (c <= 6) set_lane(0, wv(0, c), c == 0, 1'b0, 2'b00);
      if (c >= 3) begin
        set_lane(1, wv(1, c - 3), c == 3, 1'b0, 2'b00);
        push_set(2, c - 3);
      end
      tick();
      if (c == 3) begin
        occ = dut.r_wptr[0] - dut.r_rptr[0];
        check("t2_occ_peak", occ, 4);
        check("t2_aligned_early", aligned, 0);
      end
      if (c == 4) begin
        check("t2_aligned", aligned, 1);
        check("t2_skew", skew_cycles, 3);
      end
    end
    clr_in();
    repeat (3) tick();
    check("t2_drained", sb_d.size(), 0);

    // Realign is a silent flush; then lane 1 arrives 7 cycles late.
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check("t3_realign_err", deskew_err, 0);
    check("t3_realign_aligned", aligned, 0);
    check("t3_realign_valid", bus.out_valid, 0);
    tick();
    for (int c = 0; c <= 7; c++) begin
      clr_in();
      if (c <= 6) set_lane(0, wv(0, c), c == 0, 1'b0, 2'b00);
      if (c == 7) set_lane(1, wv(1, 0), 1'b1, 1'b0, 2'b00);
      tick();
      check("t3_timeout_err", deskew_err, c == 6);
      if (c == 6) begin
        occ = dut.r_wptr[0] - dut.r_rptr[0];
        check("t3_fifo_empty", occ, 0);
        check("t3_aligned", aligned, 0);
      end
    end
    clr_in();
    realign = 1'b1;
    tick();
    realign = 1'b0;

    // Marker on lane 0 only while aligned.
    for (int l = 0; l < 2; l++) set_lane(l, wv(l, 0), 1'b1, 1'b0, 2'b00);
    push_set(2, 0);
    tick();
    for (int l = 0; l < 2; l++) set_lane(l, wv(l, 1), 1'b0, 1'b0, 2'b00);
    push_set(2, 1);
    tick();
    check("t4_aligned", aligned, 1);
    set_lane(0, wv(0, 0), 1'b1, 1'b0, 2'b00);
    set_lane(1, wv(1, 2), 1'b0, 1'b0, 2'b00);
    tick();
    clr_in();
    tick();
    check("t4_mismatch_err", deskew_err, 1);
    check("t4_mismatch_valid", bus.out_valid, 0);
    check("t4_mismatch_aligned", aligned, 0);
    tick();
    check("t4_err_clear", deskew_err, 0);
    for (int l = 0; l < 2; l++) set_lane(l, wv(l, 0), 1'b1, 1'b0, 2'b00);
    push_set(2, 0);
    tick();
    for (int l = 0; l < 2; l++) set_lane(l, wv(l, 1), 1'b0, 1'b0, 2'b00);
    push_set(2, 1);
    tick();
    check("t4_realigned", aligned, 1);
    clr_in();
    repeat (2) tick();
    check("t4_drained", sb_d.size(), 0);

    // mode128 with all 16 lanes; sync 2'b10 blocks are not markers.
    n = 5'd16;
    mode128 = 1'b1;
    tick();
    check("t5_nchg_err", deskew_err, 1);
    tick();
    for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b1, 2'b10);
    tick();
    clr_in();
    tick();
    check("t5_sync10_not_marker", aligned, 0);
    for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b1, 2'b01);
    push_bus(16);
    tick();
    check("t5_aligned_at_k", aligned, 0);
    for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b1, 2'b10);
    push_bus(16);
    tick();
    check("t5_aligned", aligned, 1);
    check("t5_out_valid", bus.out_valid, 1);
    for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b0, 2'b00);
    push_bus(16);
    tick();
    clr_in();
    repeat (2) tick();
    check("t5_drained", sb_d.size(), 0);

    // Overflow of lane 0 while the other lanes starve.
    for (int c = 0; c <= 8; c++) begin
      clr_in();
      set_lane(0, $urandom(), 1'b0, 1'b0, 2'b00);
      tick();
      check("t6_ovf_err", deskew_err, c == 8);
    end
    check("t6_ovf_aligned", aligned, 0);
    for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b1, 2'b01);
    push_bus(16);
    tick();
    clr_in();
    tick();
    check("t6_realigned", aligned, 1);

    // Overflow coinciding with realign: flush without an error pulse.
    for (int c = 0; c <= 8; c++) begin
      clr_in();
      set_lane(0, $urandom(), 1'b0, 1'b0, 2'b00);
      realign = (c == 8);
      tick();
    end
    realign = 1'b0;
    clr_in();
    check("t6_realign_ovf_err", deskew_err, 0);
    check("t6_realign_ovf_aligned", aligned, 0);
    occ = dut.r_wptr[0] - dut.r_rptr[0];
    check("t6_realign_ovf_empty", occ, 0);
    tick();
    check("t6_realign_ovf_err_next", deskew_err, 0);

    // Asynchronous reset in the middle of a stream.
    for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b1, 2'b01);
    push_bus(16);
    tick();
    for (int j = 0; j < 3; j++) begin
      for (int l = 0; l < LANES; l++) set_lane(l, $urandom(), 1'b0, 1'b0, 2'b00);
      push_bus(16);
      tick();
    end
    check("t7_pre_reset_valid", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    sb_d.delete();
    sb_k.delete();
    check("t7_rst_valid", bus.out_valid, 0);
    check("t7_rst_data", bus.out_data, 0);
    check("t7_rst_datak", bus.out_datak, 0);
    check("t7_rst_aligned", aligned, 0);
    check("t7_rst_err", deskew_err, 0);
    check("t7_rst_skew", skew_cycles, 0);
    clr_in();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("t7_post_aligned", aligned, 0);
    check("t7_post_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
